// File: rtl/nanov_peri_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nanov_peri_pkg
// Description : Shared definitions for the nanoV peripheral hub: register
//               offsets, register-select encoding, status bit positions and
//               small helper functions used by the bus decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package nanov_peri_pkg;

    // Register offsets from the hub base address
    localparam logic [31:0] c_off_gpio      = 32'h0000_0000;
    localparam logic [31:0] c_off_gpio_out  = 32'h0000_0004;
    localparam logic [31:0] c_off_uart      = 32'h0000_0010;
    localparam logic [31:0] c_off_uart_stat = 32'h0000_0014;
    localparam logic [31:0] c_off_tcount    = 32'h0000_0018;
    localparam logic [31:0] c_off_tcmp      = 32'h0000_001C;

    // Register currently addressed by the CPU
    typedef enum logic [2:0] {
        SEL_NONE      = 3'd0,
        SEL_GPIO      = 3'd1,
        SEL_GPIO_OUT  = 3'd2,
        SEL_UART      = 3'd3,
        SEL_UART_STAT = 3'd4,
        SEL_TCOUNT    = 3'd5,
        SEL_TCMP      = 3'd6
    } sel_e;

    // UART status register bit positions
    localparam int c_stat_tx_busy     = 0;
    localparam int c_stat_rx_nonempty = 1;
    localparam int c_stat_rx_full     = 2;
    localparam int c_stat_tx_drop     = 3;
    localparam int c_stat_rx_cnt_lsb  = 8;
    localparam int c_stat_rx_cnt_msb  = 15;

    // Store data arrives LSB-first on the bus, so bit 31 carries bit 0
    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Exact-match address decode; anything outside the map selects nothing
    function automatic sel_e decode_addr(input logic [31:0] addr,
                                         input logic [31:0] base);
        sel_e s;
        s = SEL_NONE;
        if (addr == base + c_off_gpio)      s = SEL_GPIO;
        if (addr == base + c_off_gpio_out)  s = SEL_GPIO_OUT;
        if (addr == base + c_off_uart)      s = SEL_UART;
        if (addr == base + c_off_uart_stat) s = SEL_UART_STAT;
        if (addr == base + c_off_tcount)    s = SEL_TCOUNT;
        if (addr == base + c_off_tcmp)      s = SEL_TCMP;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Small single-clock FIFO with first-word-fall-through head
//               output. Pushes while full and pops while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                c_aw         = $clog2(DEPTH);
    localparam logic [c_aw:0]     c_full_count = (c_aw + 1)'(DEPTH);

    logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_aw:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == c_full_count);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Next-state: pointer advance, storage write and occupancy tracking
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State register with synchronous reset to empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nanov_peri_hub.sv
`default_nettype none
// ============================================================================
// Module      : nanov_peri_hub
// Description : Memory-mapped peripheral hub for the nanoV CPU. Decodes a
//               register window from the serial load/store strobes and
//               exposes GPIO, UART TX/RX (with RX FIFO), sticky status and a
//               prescaled 32-bit timer with compare output.
// Revision    : 1.0 - initial release
// ============================================================================
module nanov_peri_hub
    import nanov_peri_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
    parameter int          GPIO_W        = 8,
    parameter int          RX_FIFO_DEPTH = 4,
    parameter int          PRESCALE      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       cpu_data_out,
    input  logic              store_addr_out,
    input  logic              store_data_out,
    input  logic              data_in_read,
    output logic [31:0]       ext_data_in,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              uart_tx_en,
    output logic [7:0]        uart_tx_data,
    input  logic              uart_tx_busy,
    input  logic              uart_rx_valid,
    input  logic [7:0]        uart_rx_data,
    output logic              uart_rx_read,
    output logic              timer_match
);

    localparam int                 c_cnt_w    = $clog2(RX_FIFO_DEPTH) + 1;
    localparam int                 c_pre_w    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESCALE - 1);

    sel_e               sel_q, sel_d;
    logic [GPIO_W-1:0]  gpio_out_q, gpio_out_d;
    logic               tx_en_q, tx_en_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_drop_q, tx_drop_d;
    logic [31:0]        tcount_q, tcount_d;
    logic [c_pre_w-1:0] presc_q, presc_d;
    logic [31:0]        tcmp_q, tcmp_d;
    logic               match_q, match_d;
    logic               pulled_q, pulled_d;

    logic [31:0]        wdata;
    logic               rx_push;
    logic               rx_pop;
    logic [7:0]         rx_head;
    logic               rx_full;
    logic               rx_empty;
    logic [c_cnt_w-1:0] rx_count;

    assign wdata = bit_rev32(cpu_data_out);

    // A pull is skipped the cycle after a pull so uart_rx has time to drop
    // its valid flag; holding off while full is the RTS backpressure path.
    assign rx_push      = rst_n && uart_rx_valid && !rx_full && !pulled_q;
    assign rx_pop       = data_in_read && (sel_q == SEL_UART) && !rx_empty;
    assign uart_rx_read = rx_push;

    assign gpio_out     = gpio_out_q;
    assign uart_tx_en   = tx_en_q;
    assign uart_tx_data = tx_data_q;
    assign timer_match  = match_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (uart_rx_data),
        .pop       (rx_pop),
        .head_data (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    // Next-state: address latch, register writes, TX launch, timer advance
    always_comb begin
        sel_d      = sel_q;
        gpio_out_d = gpio_out_q;
        tx_en_d    = 1'b0;
        tx_data_d  = tx_data_q;
        tx_drop_d  = tx_drop_q;
        tcmp_d     = tcmp_q;
        pulled_d   = rx_push;

        if (presc_q == c_pre_last) begin
            presc_d  = '0;
            tcount_d = tcount_q + 32'd1;
        end else begin
            presc_d  = presc_q + 1'b1;
            tcount_d = tcount_q;
        end

        if (store_addr_out) begin
            sel_d = decode_addr(cpu_data_out, BASE_ADDR);
        end

        // Writes act on the register selected before this cycle's strobe
        if (store_data_out) begin
            case (sel_q)
                SEL_GPIO: gpio_out_d = wdata[GPIO_W-1:0];
                SEL_UART: begin
                    if (uart_tx_busy) begin
                        tx_drop_d = 1'b1;
                    end else begin
                        tx_en_d   = 1'b1;
                        tx_data_d = wdata[7:0];
                    end
                end
                SEL_TCOUNT: begin
                    tcount_d = wdata;
                    presc_d  = '0;
                end
                SEL_TCMP: tcmp_d = wdata;
                default: ;
            endcase
        end

        // Reading status acknowledges the sticky drop flag
        if (data_in_read && (sel_q == SEL_UART_STAT)) begin
            tx_drop_d = 1'b0;
        end

        match_d = (tcount_d >= tcmp_d);
    end

    // Load data mux; unmapped and write-only selections read as zero
    always_comb begin
        ext_data_in = '0;
        case (sel_q)
            SEL_GPIO:     ext_data_in = 32'(gpio_in);
            SEL_GPIO_OUT: ext_data_in = 32'(gpio_out_q);
            SEL_UART: begin
                if (!rx_empty) begin
                    ext_data_in = 32'(rx_head);
                end
            end
            SEL_UART_STAT: begin
                ext_data_in[c_stat_tx_busy]     = uart_tx_busy;
                ext_data_in[c_stat_rx_nonempty] = !rx_empty;
                ext_data_in[c_stat_rx_full]     = rx_full;
                ext_data_in[c_stat_tx_drop]     = tx_drop_q;
                ext_data_in[c_stat_rx_cnt_msb:c_stat_rx_cnt_lsb] = 8'(rx_count);
            end
            SEL_TCOUNT:   ext_data_in = tcount_q;
            SEL_TCMP:     ext_data_in = tcmp_q;
            default:      ext_data_in = '0;
        endcase
    end

    // State register; reset also discards any strobe in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q      <= SEL_NONE;
            gpio_out_q <= '0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_drop_q  <= 1'b0;
            tcount_q   <= '0;
            presc_q    <= '0;
            tcmp_q     <= 32'hFFFF_FFFF;
            match_q    <= 1'b0;
            pulled_q   <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            gpio_out_q <= gpio_out_d;
            tx_en_q    <= tx_en_d;
            tx_data_q  <= tx_data_d;
            tx_drop_q  <= tx_drop_d;
            tcount_q   <= tcount_d;
            presc_q    <= presc_d;
            tcmp_q     <= tcmp_d;
            match_q    <= match_d;
            pulled_q   <= pulled_d;
        end
    end

endmodule
`default_nettype wire
